// File: rtl/adder_collect.sv
// Serial-to-parallel collector: gathers num samples into one group for an adder tree.
// Ports: clk, rst_n, valid/din/ready in, i0..i15 group out, valid_out pulse, count.
// Outputs i{num}..i15 are tied to zero. Optional flush port: ADDER_COLLECT_FLUSH_EN.
module adder_collect #(
  parameter int bits = 8,
  parameter int num  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid,
`ifdef ADDER_COLLECT_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic [bits-1:0]            din,
  output logic                       ready,
  output logic [bits-1:0]            i0,
  output logic [bits-1:0]            i1,
  output logic [bits-1:0]            i2,
  output logic [bits-1:0]            i3,
  output logic [bits-1:0]            i4,
  output logic [bits-1:0]            i5,
  output logic [bits-1:0]            i6,
  output logic [bits-1:0]            i7,
  output logic [bits-1:0]            i8,
  output logic [bits-1:0]            i9,
  output logic [bits-1:0]            i10,
  output logic [bits-1:0]            i11,
  output logic [bits-1:0]            i12,
  output logic [bits-1:0]            i13,
  output logic [bits-1:0]            i14,
  output logic [bits-1:0]            i15,
  output logic                       valid_out,
  output logic [$clog2(num+1)-1:0]   count
);

  localparam int CW = $clog2(num + 1);
  localparam logic [CW-1:0] LAST = CW'(num - 1);

`ifdef ADDER_COLLECT_FLUSH_EN
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1
  } state_t;
`endif

  state_t          state;
  logic [bits-1:0] fill  [num];
  logic [bits-1:0] out_q [num];
  logic [bits-1:0] grp   [num];
  logic [bits-1:0] out_x [16];
  logic            xfer;
  logic            last;
  logic            fl;
  logic [CW-1:0]   cnt_inc;

  // EMIT and FLUSH both present a fresh group for exactly one cycle.
  assign valid_out = (state != FILL);

  always_comb begin
    xfer    = valid & ready;
    cnt_inc = count + CW'(xfer);
    last    = xfer && (count == LAST);
    fl      = 1'b0;
`ifdef ADDER_COLLECT_FLUSH_EN
    fl = flush && (state == FILL) &&
         !last && (cnt_inc != '0);
`endif
    // Bypass the sample taken this edge; zero slots not yet filled.
    for (int k = 0; k < num; k++) begin
      grp[k] = fill[k];
      if (xfer && int'(count) == k)
        grp[k] = din;
      if (int'(cnt_inc) <= k)
        grp[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      count <= '0;
      ready <= 1'b0;
      for (int k = 0; k < num; k++) begin
        fill[k]  <= '0;
        out_q[k] <= '0;
      end
    end else begin
      ready <= 1'b1;
      for (int k = 0; k < num; k++)
        if (xfer && int'(count) == k)
          fill[k] <= din;
      unique case (1'b1)
        last: begin
          state <= EMIT;
          count <= '0;
          for (int k = 0; k < num; k++)
            out_q[k] <= grp[k];
        end
`ifdef ADDER_COLLECT_FLUSH_EN
        fl: begin
          state <= FLUSH;
          count <= '0;
          ready <= 1'b0;
          for (int k = 0; k < num; k++)
            out_q[k] <= grp[k];
        end
`endif
        default: begin
          state <= FILL;
          count <= cnt_inc;
        end
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 16; k++)
      out_x[k] = '0;
    for (int k = 0; k < num; k++)
      out_x[k] = out_q[k];
  end

  assign i0  = out_x[0];
  assign i1  = out_x[1];
  assign i2  = out_x[2];
  assign i3  = out_x[3];
  assign i4  = out_x[4];
  assign i5  = out_x[5];
  assign i6  = out_x[6];
  assign i7  = out_x[7];
  assign i8  = out_x[8];
  assign i9  = out_x[9];
  assign i10 = out_x[10];
  assign i11 = out_x[11];
  assign i12 = out_x[12];
  assign i13 = out_x[13];
  assign i14 = out_x[14];
  assign i15 = out_x[15];

endmodule
